// File: rtl/conv_row_multiplier_if.sv
// Weight-load, pixel-stream and product-vector signals between a pixel source and conv_row_multiplier.
// Master drives weights/pixels and consumes products; slave is the multiplier block.
interface conv_row_multiplier_if #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8
);
  localparam int PRODUCT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int OUT_WIDTH     = PRODUCT_WIDTH * KERNEL_SIZE;

  logic                                 wgt_load;
  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]  wgt_dataIn;
  logic                                 pix_valid;
  logic                                 pix_ready;
  logic [DATA_WIDTH-1:0]                pix_dataIn;
  logic                                 mult_en;
  logic [OUT_WIDTH-1:0]                 mult_dataOut;
  logic                                 row_done;

  modport master (
    output wgt_load, wgt_dataIn, pix_valid, pix_dataIn,
    input  pix_ready, mult_en, mult_dataOut, row_done
  );

  modport slave (
    input  wgt_load, wgt_dataIn, pix_valid, pix_dataIn,
    output pix_ready, mult_en, mult_dataOut, row_done
  );
endinterface

// File: rtl/conv_row_multiplier.sv
// Sliding-window tap x weight multiplier feeding the convolution adder tree; 1-cycle registered output,
// or 2 cycles when MULT_PIPE2_EN is defined. Stalls on pix_valid=0; wgt_load blocks pixels and restarts the row.
module conv_row_multiplier #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ROW_LEN      = 8
) (
  input logic                   clk,
  input logic                   rstn,
  conv_row_multiplier_if.slave  bus
);
  localparam int PRODUCT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int OUT_WIDTH     = PRODUCT_WIDTH * KERNEL_SIZE;
  localparam int COL_W         = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0] FULL_COL = COL_W'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {WAIT_WGT, FILL, STREAM} state_t;

  state_t                                   state, state_n;
  logic [COL_W-1:0]                         col, col_n;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]   taps, taps_n;
  logic [KERNEL_SIZE-1:0][WEIGHT_WIDTH-1:0] wgt, wgt_n;
  logic [KERNEL_SIZE-1:0][PRODUCT_WIDTH-1:0] prod;
  logic                                     accept, produce, last;

  logic                 en1, done1;
  logic [OUT_WIDTH-1:0] dat1;

  assign bus.pix_ready = (state != WAIT_WGT) && !bus.wgt_load;
  assign accept        = bus.pix_valid && bus.pix_ready;

  // A weight load always wins and restarts the row, so a window never mixes weight sets.
  always_comb begin
    state_n = state;
    col_n   = col;
    taps_n  = taps;
    wgt_n   = wgt;
    produce = 1'b0;
    last    = 1'b0;
    if (bus.wgt_load) begin
      wgt_n   = bus.wgt_dataIn;
      col_n   = '0;
      state_n = FILL;
    end else if (accept) begin
      for (int k = 0; k < KERNEL_SIZE - 1; k++) taps_n[k] = taps[k+1];
      taps_n[KERNEL_SIZE-1] = bus.pix_dataIn;
      produce = (state == STREAM) || (col == FULL_COL);
      if (col == LAST_COL) begin
        last    = 1'b1;
        col_n   = '0;
        state_n = FILL;
      end else begin
        col_n = col + 1'b1;
        if (produce) state_n = STREAM;
      end
    end
  end

  // Products are formed from the post-shift window so the register captures the vector of this accept.
  always_comb begin
    for (int k = 0; k < KERNEL_SIZE; k++)
      prod[k] = PRODUCT_WIDTH'(taps_n[k]) * PRODUCT_WIDTH'(wgt[k]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= WAIT_WGT;
      col   <= '0;
      taps  <= '0;
      wgt   <= '0;
      en1   <= 1'b0;
      done1 <= 1'b0;
      dat1  <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      taps  <= taps_n;
      wgt   <= wgt_n;
      en1   <= produce;
      done1 <= produce && last;
      if (produce) dat1 <= prod;
    end
  end

`ifdef MULT_PIPE2_EN
  logic                 en2, done2;
  logic [OUT_WIDTH-1:0] dat2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      en2   <= 1'b0;
      done2 <= 1'b0;
      dat2  <= '0;
    end else begin
      en2   <= en1;
      done2 <= done1;
      if (en1) dat2 <= dat1;
    end
  end

  assign bus.mult_en      = en2;
  assign bus.mult_dataOut = dat2;
  assign bus.row_done     = done2;
`else
  assign bus.mult_en      = en1;
  assign bus.mult_dataOut = dat1;
  assign bus.row_done     = done1;
`endif

endmodule
